// File: rtl/mem_responder_if.sv
// Core request/response and RAM port signals of mem_responder.
// slave: the responder; master: the core plus RAM side driving it.
interface mem_responder_if;
  logic        en_mem;
  logic [1:0]  W_R_mem;
  logic [1:0]  wordsize_mem;
  logic        sign_mem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic        busy_mem;
  logic        done_mem;
  logic        aligned_mem;
  logic [29:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_be;
  logic        ram_we;
  logic        ram_req;
  logic [31:0] ram_rdata;
  logic        ram_ready;

  modport slave (
    input  en_mem, W_R_mem, wordsize_mem, sign_mem, addr, wdata, ram_rdata, ram_ready,
    output rdata, inst, busy_mem, done_mem, aligned_mem,
           ram_addr, ram_wdata, ram_be, ram_we, ram_req
  );

  modport master (
    output en_mem, W_R_mem, wordsize_mem, sign_mem, addr, wdata, ram_rdata, ram_ready,
    input  rdata, inst, busy_mem, done_mem, aligned_mem,
           ram_addr, ram_wdata, ram_be, ram_we, ram_req
  );
endinterface

// File: rtl/mem_responder.sv
// Bridges the core's load/store/fetch strobe to a single-request word RAM.
// Optional MEM_RESP_TIMEOUT_EN: abort to ERROR if ram_ready never arrives.
module mem_responder #(
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] RESET_INST = 32'h00000013
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_FETCH = 2'b11;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;

  logic [1:0]  state, state_nxt;
  logic        en_prev;
  logic [1:0]  op_q, op_nxt;
  logic [1:0]  size_q, size_nxt;
  logic [1:0]  off_q, off_nxt;
  logic        sign_q, sign_nxt;
  logic        busy_nxt, done_nxt, aligned_nxt, req_nxt, we_nxt;
  logic [3:0]  be_nxt;
  logic [29:0] raddr_nxt;
  logic [31:0] wdata_nxt, rdata_nxt, inst_nxt;
  logic        start_c, misaligned_c;

`ifdef MEM_RESP_TIMEOUT_EN
  localparam int unsigned CNT_W = ((TIMEOUT + 1) > 256) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_nxt;
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT);
`endif

  assign start_c = bus.en_mem & ~en_prev;

  // Alignment of the request being captured this edge; fetches are always word-sized.
  always_comb begin
    misaligned_c = 1'b0;
    if (bus.W_R_mem == OP_FETCH) begin
      misaligned_c = (bus.addr[1:0] != 2'b00);
    end else begin
      case (bus.wordsize_mem)
        SZ_BYTE: misaligned_c = 1'b0;
        SZ_HALF: misaligned_c = bus.addr[0];
        default: misaligned_c = (bus.addr[1:0] != 2'b00);
      endcase
    end
  end

  function automatic logic [31:0] format_load(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic sgn);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: format_load = {{24{sgn & b[7]}}, b};
      SZ_HALF: format_load = {{16{sgn & h[15]}}, h};
      default: format_load = word;
    endcase
  endfunction

  // Next state and next registered outputs.
  always_comb begin
    state_nxt   = state;
    op_nxt      = op_q;
    size_nxt    = size_q;
    off_nxt     = off_q;
    sign_nxt    = sign_q;
    busy_nxt    = bus.busy_mem;
    done_nxt    = 1'b0;
    aligned_nxt = bus.aligned_mem;
    req_nxt     = bus.ram_req;
    we_nxt      = bus.ram_we;
    be_nxt      = bus.ram_be;
    raddr_nxt   = bus.ram_addr;
    wdata_nxt   = bus.ram_wdata;
    rdata_nxt   = bus.rdata;
    inst_nxt    = bus.inst;
`ifdef MEM_RESP_TIMEOUT_EN
    cnt_nxt     = cnt_q;
`endif
    case (state)
      IDLE: begin
        if (start_c) begin
          op_nxt   = bus.W_R_mem;
          size_nxt = bus.wordsize_mem;
          off_nxt  = bus.addr[1:0];
          sign_nxt = bus.sign_mem;
          if (misaligned_c) begin
            state_nxt   = ERROR;
            aligned_nxt = 1'b0;
          end else begin
            state_nxt = ACCESS;
            busy_nxt  = 1'b1;
            req_nxt   = 1'b1;
            we_nxt    = (bus.W_R_mem == OP_WRITE);
            raddr_nxt = bus.addr[31:2];
            be_nxt    = 4'hF;
            wdata_nxt = bus.wdata;
            if (bus.W_R_mem == OP_WRITE) begin
              case (bus.wordsize_mem)
                SZ_BYTE: begin
                  be_nxt    = 4'(4'b0001 << bus.addr[1:0]);
                  wdata_nxt = {4{bus.wdata[7:0]}};
                end
                SZ_HALF: begin
                  be_nxt    = bus.addr[1] ? 4'b1100 : 4'b0011;
                  wdata_nxt = {2{bus.wdata[15:0]}};
                end
                default: ;
              endcase
            end
`ifdef MEM_RESP_TIMEOUT_EN
            cnt_nxt = '0;
`endif
          end
        end
      end
      ACCESS: begin
        if (bus.ram_ready) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          req_nxt   = 1'b0;
          we_nxt    = 1'b0;
          be_nxt    = 4'h0;
          done_nxt  = 1'b1;
          if (op_q == OP_FETCH) begin
            inst_nxt = bus.ram_rdata;
          end else if (op_q != OP_WRITE) begin
            rdata_nxt = format_load(bus.ram_rdata, size_q, off_q, sign_q);
          end
        end
`ifdef MEM_RESP_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_nxt   = ERROR;
          busy_nxt    = 1'b0;
          req_nxt     = 1'b0;
          we_nxt      = 1'b0;
          be_nxt      = 4'h0;
          aligned_nxt = 1'b0;
        end else begin
          cnt_nxt = cnt_q + CNT_W'(1);
        end
`endif
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      en_prev         <= 1'b0;
      op_q            <= 2'b00;
      size_q          <= 2'b00;
      off_q           <= 2'b00;
      sign_q          <= 1'b0;
      bus.busy_mem    <= 1'b0;
      bus.done_mem    <= 1'b0;
      bus.aligned_mem <= 1'b1;
      bus.ram_req     <= 1'b0;
      bus.ram_we      <= 1'b0;
      bus.ram_be      <= 4'h0;
      bus.ram_addr    <= 30'h0;
      bus.ram_wdata   <= 32'h0;
      bus.rdata       <= 32'h0;
      bus.inst        <= RESET_INST;
`ifdef MEM_RESP_TIMEOUT_EN
      cnt_q           <= '0;
`endif
    end else begin
      state           <= state_nxt;
      en_prev         <= bus.en_mem;
      op_q            <= op_nxt;
      size_q          <= size_nxt;
      off_q           <= off_nxt;
      sign_q          <= sign_nxt;
      bus.busy_mem    <= busy_nxt;
      bus.done_mem    <= done_nxt;
      bus.aligned_mem <= aligned_nxt;
      bus.ram_req     <= req_nxt;
      bus.ram_we      <= we_nxt;
      bus.ram_be      <= be_nxt;
      bus.ram_addr    <= raddr_nxt;
      bus.ram_wdata   <= wdata_nxt;
      bus.rdata       <= rdata_nxt;
      bus.inst        <= inst_nxt;
`ifdef MEM_RESP_TIMEOUT_EN
      cnt_q           <= cnt_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (covers MEM_RESP_TIMEOUT_EN when defined).
module tb_mem_responder;
  localparam int unsigned TIMEOUT    = 4;
  localparam logic [31:0] RESET_INST = 32'h00000013;

  logic clk = 1'b0;
  logic reset;
  int   passed = 0;
  int   checks = 0;
  logic [31:0] exp_rdata;
  logic [31:0] exp_inst;

  mem_responder_if bus();

  mem_responder #(.TIMEOUT(TIMEOUT), .RESET_INST(RESET_INST)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Load table: op, size, sign, addr, expected rdata for ram_rdata = 0x80FF1122.
  localparam logic [1:0]  LD_OP   [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
  localparam logic [1:0]  LD_SZ   [8] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10};
  localparam logic        LD_SG   [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [31:0] LD_ADDR [8] = '{32'h203, 32'h203, 32'h201, 32'h202, 32'h202, 32'h200, 32'h200, 32'h204};
  localparam logic [31:0] LD_EXP  [8] = '{32'hFFFFFF80, 32'h00000080, 32'h00000011, 32'hFFFFFFFF,
                                          32'hFFFF80FF, 32'h00001122, 32'h00000022, 32'h80FF1122};

  // Store table: size, addr, wdata, expected ram_be, expected ram_wdata.
  localparam logic [1:0]  ST_SZ   [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  localparam logic [31:0] ST_ADDR [4] = '{32'h201, 32'h300, 32'h10C, 32'h110};
  localparam logic [31:0] ST_WD   [4] = '{32'h0000005A, 32'h1234ABCD, 32'hDEADBEEF, 32'hCAFEF00D};
  localparam logic [3:0]  ST_BE   [4] = '{4'b0010, 4'b0011, 4'b1111, 4'b1111};
  localparam logic [31:0] ST_EXP  [4] = '{32'h5A5A5A5A, 32'hABCDABCD, 32'hDEADBEEF, 32'hCAFEF00D};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  // Single-cycle en_mem pulse; returns one step after the accepting edge.
  task automatic start_req(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                           input logic [31:0] a, input logic [31:0] w);
    bus.W_R_mem      = op;
    bus.wordsize_mem = size;
    bus.sign_mem     = sgn;
    bus.addr         = a;
    bus.wdata        = w;
    bus.en_mem       = 1'b1;
    tick();
    bus.en_mem       = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) tick();
    checks++; if (bus.busy_mem !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_mem); else passed++;
    checks++; if (bus.done_mem !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done_mem); else passed++;
    checks++; if (bus.aligned_mem !== 1'b1) $display("FAIL reset_aligned: got %b want 1", bus.aligned_mem); else passed++;
    checks++; if ({bus.ram_req, bus.ram_we, bus.ram_be} !== 6'b0)
      $display("FAIL reset_ram_ctl: got req=%b we=%b be=%b want 0", bus.ram_req, bus.ram_we, bus.ram_be); else passed++;
    checks++; if ({bus.ram_addr, bus.ram_wdata} !== 62'h0)
      $display("FAIL reset_ram_data: got addr=%h wdata=%h want 0", bus.ram_addr, bus.ram_wdata); else passed++;
    checks++; if (bus.rdata !== 32'h0) $display("FAIL reset_rdata: got %h want 0", bus.rdata); else passed++;
    checks++; if (bus.inst !== RESET_INST) $display("FAIL reset_inst: got %h want %h", bus.inst, RESET_INST); else passed++;
    reset = 1'b0;
    repeat (2) tick();
    checks++; if ({bus.busy_mem, bus.ram_req, bus.aligned_mem} !== 3'b001)
      $display("FAIL reset_idle: got busy=%b req=%b aligned=%b want 0 0 1", bus.busy_mem, bus.ram_req, bus.aligned_mem); else passed++;
  endtask

  task automatic test_fetch;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h00A00093;
    start_req(2'b11, 2'b00, 1'b0, 32'h100, 32'h0);
    checks++; if ({bus.ram_req, bus.busy_mem, bus.ram_we, bus.done_mem} !== 4'b1100)
      $display("FAIL fetch_t0_ctl: got req=%b busy=%b we=%b done=%b want 1 1 0 0",
               bus.ram_req, bus.busy_mem, bus.ram_we, bus.done_mem); else passed++;
    checks++; if (bus.ram_addr !== 30'h40) $display("FAIL fetch_addr: got %h want 40", bus.ram_addr); else passed++;
    checks++; if (bus.ram_be !== 4'hF) $display("FAIL fetch_be: got %b want 1111", bus.ram_be); else passed++;
    tick();
    checks++; if ({bus.done_mem, bus.ram_req, bus.busy_mem} !== 3'b100)
      $display("FAIL fetch_t1_done: got done=%b req=%b busy=%b want 1 0 0", bus.done_mem, bus.ram_req, bus.busy_mem); else passed++;
    checks++; if (bus.inst !== 32'h00A00093) $display("FAIL fetch_inst: got %h want 00a00093", bus.inst); else passed++;
    exp_inst = 32'h00A00093;
    tick();
    checks++; if (bus.done_mem !== 1'b0) $display("FAIL fetch_t2_done: got %b want 0", bus.done_mem); else passed++;
  endtask

  task automatic test_loads;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h80FF1122;
    for (int i = 0; i < 8; i++) begin
      start_req(LD_OP[i], LD_SZ[i], LD_SG[i], LD_ADDR[i], 32'h0);
      tick();
      checks++; if ({bus.done_mem, bus.rdata} !== {1'b1, LD_EXP[i]})
        $display("FAIL load_%0d: got done=%b rdata=%h want 1 %h", i, bus.done_mem, bus.rdata, LD_EXP[i]); else passed++;
      exp_rdata = LD_EXP[i];
      tick();
    end
    checks++; if (bus.inst !== exp_inst) $display("FAIL load_inst_hold: got %h want %h", bus.inst, exp_inst); else passed++;
  endtask

  task automatic test_stores;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'h55555555;
    for (int i = 0; i < 4; i++) begin
      start_req(2'b01, ST_SZ[i], 1'b0, ST_ADDR[i], ST_WD[i]);
      checks++; if ({bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr} !==
                    {1'b1, 1'b1, ST_BE[i], ST_EXP[i], ST_ADDR[i][31:2]})
        $display("FAIL store_%0d: got req=%b we=%b be=%b wdata=%h addr=%h want 1 1 %b %h %h", i, bus.ram_req,
                 bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr, ST_BE[i], ST_EXP[i], ST_ADDR[i][31:2]); else passed++;
      tick();
      checks++; if ({bus.done_mem, bus.rdata, bus.inst} !== {1'b1, exp_rdata, exp_inst})
        $display("FAIL store_%0d_done: got done=%b rdata=%h inst=%h want 1 %h %h", i, bus.done_mem, bus.rdata,
                 bus.inst, exp_rdata, exp_inst); else passed++;
      tick();
    end
  endtask

  task automatic test_delayed_store;
    int dcount;
    bus.ram_ready = 1'b0;
    start_req(2'b01, 2'b01, 1'b0, 32'h302, 32'h1234ABCD);
    for (int c = 0; c < 4; c++) begin
      checks++; if ({bus.ram_req, bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr, bus.busy_mem, bus.done_mem} !==
                    {1'b1, 1'b1, 4'b1100, 32'hABCDABCD, 30'hC0, 1'b1, 1'b0})
        $display("FAIL dstore_hold_%0d: got req=%b we=%b be=%b wdata=%h addr=%h busy=%b done=%b", c, bus.ram_req,
                 bus.ram_we, bus.ram_be, bus.ram_wdata, bus.ram_addr, bus.busy_mem, bus.done_mem); else passed++;
      if (c < 3) tick();
    end
    bus.ram_ready = 1'b1;
    dcount = 0;
    repeat (6) begin
      tick();
      if (bus.done_mem === 1'b1) dcount++;
    end
    checks++; if (dcount !== 1) $display("FAIL dstore_done_count: got %0d want 1", dcount); else passed++;
    checks++; if ({bus.ram_req, bus.busy_mem} !== 2'b00)
      $display("FAIL dstore_after: got req=%b busy=%b want 0 0", bus.ram_req, bus.busy_mem); else passed++;
  endtask

  task automatic test_en_held;
    int dcount;
    bus.ram_ready    = 1'b1;
    bus.ram_rdata    = 32'h12345678;
    bus.W_R_mem      = 2'b11;
    bus.wordsize_mem = 2'b10;
    bus.addr         = 32'h104;
    bus.en_mem       = 1'b1;
    dcount = 0;
    tick();
    tick();
    if (bus.done_mem === 1'b1) dcount++;
    bus.en_mem = 1'b0;
    repeat (6) begin
      tick();
      if (bus.done_mem === 1'b1) dcount++;
    end
    checks++; if (dcount !== 1) $display("FAIL en_held_count: got %0d want 1", dcount); else passed++;
    checks++; if (bus.inst !== 32'h12345678) $display("FAIL en_held_inst: got %h want 12345678", bus.inst); else passed++;
  endtask

  task automatic test_reset_mid_access;
    int dcount;
    bus.ram_ready = 1'b0;
    start_req(2'b00, 2'b10, 1'b0, 32'h400, 32'h0);
    checks++; if (bus.ram_req !== 1'b1) $display("FAIL abort_req_before: got %b want 1", bus.ram_req); else passed++;
    tick();
    reset = 1'b1;
    #1;
    checks++; if ({bus.ram_req, bus.busy_mem} !== 2'b00)
      $display("FAIL abort_async: got req=%b busy=%b want 0 0", bus.ram_req, bus.busy_mem); else passed++;
    tick();
    reset = 1'b0;
    bus.ram_ready = 1'b1;
    dcount = 0;
    repeat (6) begin
      tick();
      if (bus.done_mem === 1'b1 || bus.ram_req === 1'b1) dcount++;
    end
    checks++; if (dcount !== 0) $display("FAIL abort_no_done: got %0d active cycles want 0", dcount); else passed++;
    checks++; if ({bus.rdata, bus.inst} !== {32'h0, RESET_INST})
      $display("FAIL abort_regs: got rdata=%h inst=%h want 0 %h", bus.rdata, bus.inst, RESET_INST); else passed++;
  endtask

  task automatic test_misaligned;
    int bad;
    bus.ram_ready = 1'b1;
    start_req(2'b00, 2'b10, 1'b1, 32'h401, 32'h0);
    checks++; if ({bus.aligned_mem, bus.ram_req, bus.done_mem} !== 3'b000)
      $display("FAIL misalign_t0: got aligned=%b req=%b done=%b want 0 0 0", bus.aligned_mem, bus.ram_req, bus.done_mem); else passed++;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.aligned_mem !== 1'b0 || bus.ram_req !== 1'b0 || bus.done_mem !== 1'b0) bad++;
    end
    start_req(2'b11, 2'b10, 1'b0, 32'h100, 32'h0);
    repeat (3) begin
      tick();
      if (bus.aligned_mem !== 1'b0 || bus.ram_req !== 1'b0 || bus.done_mem !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL misalign_sticky: got %0d bad cycles want 0", bad); else passed++;
    reset = 1'b1;
    #1;
    checks++; if (bus.aligned_mem !== 1'b1) $display("FAIL misalign_reset: got %b want 1", bus.aligned_mem); else passed++;
    tick();
    reset = 1'b0;
    tick();
    start_req(2'b01, 2'b01, 1'b0, 32'h301, 32'h0);
    checks++; if ({bus.aligned_mem, bus.ram_req} !== 2'b00)
      $display("FAIL misalign_half: got aligned=%b req=%b want 0 0", bus.aligned_mem, bus.ram_req); else passed++;
    do_reset();
    start_req(2'b11, 2'b00, 1'b0, 32'h102, 32'h0);
    checks++; if ({bus.aligned_mem, bus.ram_req} !== 2'b00)
      $display("FAIL misalign_fetch: got aligned=%b req=%b want 0 0", bus.aligned_mem, bus.ram_req); else passed++;
    do_reset();
  endtask

`ifdef MEM_RESP_TIMEOUT_EN
  task automatic test_timeout;
    bus.ram_ready = 1'b0;
    start_req(2'b00, 2'b10, 1'b0, 32'h500, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      tick();
      checks++; if ({bus.ram_req, bus.aligned_mem} !== 2'b11)
        $display("FAIL timeout_wait_%0d: got req=%b aligned=%b want 1 1", c, bus.ram_req, bus.aligned_mem); else passed++;
    end
    tick();
    checks++; if ({bus.ram_req, bus.aligned_mem, bus.busy_mem} !== 3'b000)
      $display("FAIL timeout_error: got req=%b aligned=%b busy=%b want 0 0 0", bus.ram_req, bus.aligned_mem, bus.busy_mem); else passed++;
    bus.ram_ready = 1'b1;
    repeat (2) tick();
    checks++; if ({bus.aligned_mem, bus.done_mem} !== 2'b00)
      $display("FAIL timeout_terminal: got aligned=%b done=%b want 0 0", bus.aligned_mem, bus.done_mem); else passed++;
    do_reset();
  endtask
`else
  task automatic test_no_timeout;
    int bad;
    bus.ram_ready = 1'b0;
    start_req(2'b00, 2'b10, 1'b0, 32'h500, 32'h0);
    bad = 0;
    repeat (300) begin
      tick();
      if (bus.ram_req !== 1'b1 || bus.aligned_mem !== 1'b1) bad++;
    end
    checks++; if (bad !== 0) $display("FAIL no_timeout_wait: got %0d bad cycles want 0", bad); else passed++;
    bus.ram_ready = 1'b1;
    bus.ram_rdata = 32'hA5A5A5A5;
    tick();
    checks++; if ({bus.done_mem, bus.rdata} !== {1'b1, 32'hA5A5A5A5})
      $display("FAIL no_timeout_done: got done=%b rdata=%h want 1 a5a5a5a5", bus.done_mem, bus.rdata); else passed++;
    tick();
  endtask
`endif

  initial begin
    bus.en_mem       = 1'b0;
    bus.W_R_mem      = 2'b00;
    bus.wordsize_mem = 2'b00;
    bus.sign_mem     = 1'b0;
    bus.addr         = 32'h0;
    bus.wdata        = 32'h0;
    bus.ram_rdata    = 32'h0;
    bus.ram_ready    = 1'b0;
    exp_rdata        = 32'h0;
    exp_inst         = RESET_INST;
    reset            = 1'b1;
    test_reset();
    test_fetch();
    test_loads();
    test_stores();
    test_delayed_store();
    test_en_held();
    test_reset_mid_access();
    test_misaligned();
`ifdef MEM_RESP_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the RAM-wait cycle limit used only when MEM_RESP_TIMEOUT_EN is defined.
REQ-002 SHALL have parameter RESET_INST, default 32'h00000013, giving the inst reset value (NOP).
REQ-003 SHALL have a single clock `clk` and an asynchronous, active-high reset `reset`; ports: clk  in  1  clock (all state on rising edge).
REQ-004 reset  in  1  async active-high reset.
REQ-005 en_mem  in  1  request strobe from core FSM; level may persist up to 2 cycles.
REQ-006 W_R_mem  in  2  00 data read, 01 data write, 11 instruction fetch, 10 treated as data read.
REQ-007 wordsize_mem  in  2  00 byte, 01 half, 10 word, 11 treated as word.
REQ-008 sign_mem  in  1  1 = sign-extend loads, 0 = zero-extend.
REQ-009 addr  in  32  byte address; wdata  in  32  store data (LSB-justified).
REQ-010 rdata  out  32  formatted load data; inst  out  32  fetched instruction.
REQ-011 busy_mem  out  1  transaction in flight; done_mem  out  1  one-cycle completion pulse; aligned_mem  out  1  0 = fatal access error (sticky).
REQ-012 ram_addr  out  30  word address; ram_wdata  out  32; ram_be  out  4; ram_we  out  1; ram_req  out  1; ram_rdata  in  32; ram_ready  in  1.

Function
REQ-013 SHALL implement states IDLE, ACCESS, DONE, ERROR.
REQ-014 SHALL accept a request only in IDLE on a cycle where en_mem=1 and en_mem was 0 the previous cycle; en_mem in other states is ignored.
REQ-015 On acceptance SHALL latch addr, wdata, W_R_mem, wordsize_mem, sign_mem; alignment is checked on the latched values.
REQ-016 Misaligned = half with addr[0]=1, word/fetch with addr[1:0]!=0; fetch is always word-sized regardless of wordsize_mem.
REQ-017 Misaligned request SHALL go IDLE->ERROR, drive aligned_mem=0 from the next cycle until reset, never assert ram_req or done_mem.
REQ-018 Aligned request SHALL go IDLE->ACCESS; in ACCESS ram_req=1, busy_mem=1, ram_addr=addr[31:2], ram_we=1 only for W_R_mem=01.
REQ-019 Stores: byte -> wdata[7:0] replicated on all lanes, ram_be=4'b0001<<addr[1:0]; half -> wdata[15:0] on both halves, ram_be=0011/1100 by addr[1]; word -> ram_be=1111. Loads/fetch: ram_be=1111.
REQ-020 ram_req and all ram_* outputs SHALL stay stable until ram_ready is sampled 1; then ACCESS->DONE.
REQ-021 On the ram_ready edge SHALL capture: fetch -> inst=ram_rdata; read -> rdata = selected byte/half lane, sign- or zero-extended to 32 bits; write -> rdata, inst unchanged.
REQ-022 In DONE: done_mem=1 for exactly one cycle, busy_mem=0, ram_req=0; DONE->IDLE unconditionally.
REQ-023 Latency with ram_ready tied 1: request sampled edge T0, ram_ready sampled T1, done_mem high between T1 and T2; minimum 2 cycles.
REQ-024 rdata and inst SHALL hold their last values until overwritten by a later read/fetch.
REQ-025 ERROR is terminal; only reset exits.

Reset
REQ-026 Asserting reset SHALL immediately force IDLE, busy_mem=0, done_mem=0, aligned_mem=1, ram_req=0, ram_we=0, ram_be=0, ram_addr=0, ram_wdata=0, rdata=0, inst=RESET_INST, en_mem history=0.
REQ-027 Reset mid-ACCESS SHALL drop ram_req asynchronously; the aborted transaction produces no done_mem after release.

Configuration
REQ-028 Macro MEM_RESP_TIMEOUT_EN: defined -> an 8-bit-min counter runs in ACCESS; if ram_ready not seen within TIMEOUT cycles, go ACCESS->ERROR, ram_req=0, aligned_mem=0; undefined -> no counter, ACCESS waits indefinitely.

Verification
REQ-029 Fetch addr=0x100, ram_ready tied 1, ram_rdata=0x00A00093 -> ram_addr=0x40, done_mem one cycle at T1..T2, inst=0x00A00093.
REQ-030 Byte load signed addr=0x203, ram_rdata=0x80FF1122 -> rdata=0xFFFFFF80; same with sign_mem=0 -> 0x00000080.
REQ-031 Half store addr=0x302, wdata=0x1234ABCD -> ram_be=1100, ram_wdata=0xABCDABCD, ram_we=1; ram_ready delayed 3 cycles -> ram_* stable throughout, one done_mem.
REQ-032 Word load addr=0x401 -> aligned_mem=0 next cycle and stays, ram_req never 1, no done_mem; reset -> aligned_mem=1.
REQ-033 en_mem held 2 cycles -> exactly one transaction; reset asserted during ACCESS -> ram_req falls same cycle, no done_mem.
REQ-034 With MEM_RESP_TIMEOUT_EN, TIMEOUT=4, ram_ready held 0 -> ERROR after 4 ACCESS cycles, aligned_mem=0, ram_req=0.
